// File: rtl/branch_pc_sequencer.sv
// Fetch PC sequencer: advances the PC by PC_STEP when enabled, accepts one branch at a time,
// evaluates its condition, then redirects with a one-cycle flush when the branch is taken.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [4:0]  br_opcode,
  input  logic [31:0] br_operand,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        br_taken,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  state_t      state_r;
  logic [31:0] pc_r;
  logic        br_ready_r;
  logic        flush_r;
  logic        br_taken_r;
  logic [15:0] taken_cnt_r;
  logic [4:0]  opcode_r;
  logic [31:0] operand_r;
  logic [31:0] target_r;
  logic        accept_s;
  logic        taken_s;

  // Branch condition decode on the captured opcode and operand.
  function automatic logic eval_taken(input logic [4:0] op, input logic [31:0] val);
    logic t;
    case (op)
      5'b10100: t = 1'b1;
      5'b10000: t = val[31];
      5'b10001: t = ~val[31] & (val != 32'h0000_0000);
      5'b10010: t = (val == 32'h0000_0000);
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

  // br_ready_r is high exactly in RUN, so it doubles as the RUN-state decode.
  assign accept_s    = br_valid & br_ready_r;
  assign taken_s     = eval_taken(opcode_r, operand_r);
  assign br_ready    = br_ready_r;
  assign fetch_valid = br_ready_r & en;
  assign pc          = pc_r;
  assign flush       = flush_r;
  assign br_taken    = br_taken_r;
  assign taken_cnt   = taken_cnt_r;

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      pc_r        <= RESET_PC;
      br_ready_r  <= 1'b1;
      flush_r     <= 1'b0;
      br_taken_r  <= 1'b0;
      taken_cnt_r <= 16'h0000;
      opcode_r    <= 5'b00000;
      operand_r   <= 32'h0000_0000;
      target_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        RUN: begin
          if (accept_s) begin
            opcode_r   <= br_opcode;
            operand_r  <= br_operand;
            target_r   <= br_target & 32'hFFFF_FFFC;
            br_ready_r <= 1'b0;
            state_r    <= EVAL;
          end else if (en) begin
            pc_r <= pc_r + PC_INC;
          end
        end
        EVAL: begin
          br_taken_r <= taken_s;
          if (taken_s) begin
            if (taken_cnt_r != 16'hFFFF) begin
              taken_cnt_r <= taken_cnt_r + 16'h0001;
            end
            flush_r <= 1'b1;
            state_r <= REDIRECT;
          end else begin
            br_ready_r <= 1'b1;
            state_r    <= RUN;
          end
        end
        REDIRECT: begin
          pc_r       <= target_r;
          flush_r    <= 1'b0;
          br_ready_r <= 1'b1;
          state_r    <= RUN;
        end
        default: begin
          flush_r    <= 1'b0;
          br_ready_r <= 1'b1;
          state_r    <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Scoreboard bench for branch_pc_sequencer: stimulus pushes expected fetches and branch
// outcomes from a transaction-level model; a negedge monitor pops and compares them.
module tb_branch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        br_valid;
  logic        br_ready;
  logic [4:0]  br_opcode;
  logic [31:0] br_operand;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        br_taken;
  logic [15:0] taken_cnt;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  branch_pc_sequencer #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .br_valid(br_valid), .br_ready(br_ready),
    .br_opcode(br_opcode), .br_operand(br_operand), .br_target(br_target), .pc(pc),
    .fetch_valid(fetch_valid), .flush(flush), .br_taken(br_taken), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
    logic [15:0] cnt;
  } br_exp_t;

  logic [31:0] pcq[$];
  br_exp_t     brq[$];
  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0;

  // Transaction-level model state
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic [31:0] pend_pc;
  int          busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_taken(input logic [4:0] op, input logic [31:0] v);
    if (op == 5'd20) return 1'b1;
    if (op == 5'd16) return $signed(v) < 0;
    if (op == 5'd17) return $signed(v) > 0;
    if (op == 5'd18) return v == 32'd0;
    return 1'b0;
  endfunction

  // One clock of stimulus; the model predicts what the DUT must present.
  task automatic cycle(input logic e, input logic bv, input logic [4:0] op,
                       input logic [31:0] opd, input logic [31:0] tgt);
    logic t;
    @(posedge clk);
    #1;
    en = e; br_valid = bv; br_opcode = op; br_operand = opd; br_target = tgt;
    if (busy == 0) begin
      if (e) pcq.push_back(m_pc);
      if (bv) begin
        t = ref_taken(op, opd);
        if (t && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        pend_pc = t ? (tgt / 32'd4) * 32'd4 : m_pc;
        brq.push_back('{taken: t, pc: pend_pc, cnt: m_cnt});
        busy = t ? 2 : 1;
      end else if (e) begin
        m_pc = m_pc + 32'd4;
      end
    end else begin
      busy--;
      if (busy == 0) m_pc = pend_pc;
    end
  endtask

  int low_cnt = 0;
  int fl_cnt  = 0;

  // Monitor: compares fetch addresses and completed branches mid-cycle.
  always @(negedge clk) begin
    br_exp_t e;
    if (!mon_en) begin
      low_cnt = 0;
      fl_cnt  = 0;
    end else begin
      if (fetch_valid) begin
        if (pcq.size() == 0) chk("fetch_unexpected", {31'd0, fetch_valid}, 32'd0);
        else chk("fetch_pc", pc, pcq.pop_front());
      end
      if (!br_ready) begin
        low_cnt++;
        if (flush) fl_cnt++;
      end else begin
        chk("flush_in_run", {31'd0, flush}, 32'd0);
        if (low_cnt > 0) begin
          if (brq.size() == 0) begin
            chk("branch_unexpected", low_cnt, 32'd0);
          end else begin
            e = brq.pop_front();
            chk("br_taken", {31'd0, br_taken}, {31'd0, e.taken});
            chk("br_pc", pc, e.pc);
            chk("taken_cnt", {16'd0, taken_cnt}, {16'd0, e.cnt});
            chk("busy_cycles", low_cnt, e.taken ? 32'd2 : 32'd1);
            chk("flush_cycles", fl_cnt, e.taken ? 32'd1 : 32'd0);
          end
          low_cnt = 0;
          fl_cnt  = 0;
        end
      end
    end
  end

  logic [4:0]  ops_tab [5] = '{5'b10100, 5'b10000, 5'b10001, 5'b10010, 5'b00011};
  logic [31:0] opd_tab [3] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000};

  initial begin
    logic [4:0]  op;
    logic [31:0] opd;
    rst_n = 1'b0; en = 1'b0; br_valid = 1'b0; br_opcode = 5'd0;
    br_operand = 32'd0; br_target = 32'd0;
    m_pc = RST_PC; m_cnt = 16'd0; busy = 0; pend_pc = 32'd0;
    #12;
    chk("rst_pc", pc, RST_PC);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
    chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("rst_br_ready", {31'd0, br_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Stall after reset, then sequential wrap
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);

    // Jump to 0x100, then unconditional branch to unaligned 0x2003
    cycle(1'b1, 1'b1, 5'b10100, 32'd0, 32'h0000_0103);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    cycle(1'b0, 1'b1, 5'b10100, 32'd0, 32'h0000_2003);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5'b10100, 32'd0, 32'h0000_7000);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);

    // Condition table plus a non-branch opcode
    for (int o = 0; o < 5; o++) begin
      for (int v = 0; v < 3; v++) begin
        cycle(1'b1, 1'b1, ops_tab[o], opd_tab[v], $urandom);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
      end
    end

    // Not-taken branch while stalled
    cycle(1'b0, 1'b1, 5'b10010, 32'd5, 32'h0000_0800);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(5, 0) == 5) ? 5'($urandom) : ops_tab[$urandom_range(4, 0)];
      case ($urandom_range(3, 0))
        0: opd = 32'd0;
        1: opd = 32'd1;
        2: opd = 32'h8000_0000 | $urandom;
        default: opd = $urandom;
      endcase
      cycle(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0), op, opd, $urandom);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    // Saturation: preload the counter near its ceiling, then three taken branches
    force dut.taken_cnt_r = 16'hFFFD;
    #1;
    release dut.taken_cnt_r;
    m_cnt = 16'hFFFD;
    for (int b = 0; b < 3; b++) begin
      cycle(1'b1, 1'b1, 5'b10100, 32'd0, 32'h0000_1000 + 32'(b) * 32'h10);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    end
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    chk("sat_cnt", {16'd0, taken_cnt}, 32'h0000_FFFF);
    chk("brq_drained", brq.size(), 32'd0);
    chk("pcq_drained", pcq.size(), 32'd0);

    // Asynchronous reset during EVAL aborts the branch
    mon_en = 1'b0;
    cycle(1'b0, 1'b1, 5'b10100, 32'd0, 32'h0000_4000);
    @(posedge clk);
    #2;
    chk("pre_rst_in_eval", {31'd0, br_ready}, 32'd0);
    rst_n = 1'b0;
    br_valid = 1'b0;
    #1;
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    chk("midrst_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("midrst_br_taken", {31'd0, br_taken}, 32'd0);
    chk("midrst_br_ready", {31'd0, br_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_flush", {31'd0, flush}, 32'd0);
      chk("postrst_pc", pc, RST_PC);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_pc_sequencer.md
BRANCH_PC_SEQUENCER -- requirements
Module: branch_pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 4, the sequential PC increment in bytes.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  fetch advance enable; low stalls the sequential PC.
REQ-006 SHALL have port br_valid  input  1  branch request valid.
REQ-007 SHALL have port br_ready  output  1  branch request accept; a transfer occurs when br_valid and br_ready are both high at a rising edge.
REQ-008 SHALL have port br_opcode  input  5  branch opcode.
REQ-009 SHALL have port br_operand  input  32  register value tested by the condition.
REQ-010 SHALL have port br_target  input  32  absolute byte target address.
REQ-011 SHALL have port pc  output  32  current fetch address, registered.
REQ-012 SHALL have port fetch_valid  output  1  pc is a valid fetch address this cycle.
REQ-013 SHALL have port flush  output  1  one-cycle kill of fetched-but-unissued instructions.
REQ-014 SHALL have port br_taken  output  1  registered outcome of the last evaluated branch.
REQ-015 SHALL have port taken_cnt  output  16  saturating count of taken branches.

Function
REQ-016 SHALL implement FSM states RUN, EVAL and REDIRECT.
REQ-017 In RUN, br_ready SHALL be 1 and fetch_valid SHALL equal en.
REQ-018 In RUN with en=1 and no branch transfer, pc SHALL advance by PC_STEP, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 In RUN with en=0, pc SHALL hold; a branch transfer SHALL still be accepted.
REQ-020 On a branch transfer in RUN, opcode, operand and {target[31:2],2'b00} SHALL be captured, pc SHALL hold that cycle, and the FSM SHALL go to EVAL.
REQ-021 In EVAL and REDIRECT, br_ready and fetch_valid SHALL be 0, and pc SHALL not advance.
REQ-022 In EVAL, the block SHALL compute taken from the captured values: 5'b10100 -> always 1; 5'b10000 -> operand[31]==1; 5'b10001 -> operand[31]==0 and operand!=0; 5'b10010 -> operand==0; any other opcode -> 0.
REQ-023 At the end of EVAL, br_taken SHALL load taken, and the FSM SHALL go to REDIRECT if taken, otherwise to RUN.
REQ-024 A not-taken branch SHALL resume in RUN with pc unchanged from its value at acceptance.
REQ-025 flush SHALL be 1 exactly while the state is REDIRECT, and 0 otherwise.
REQ-026 At the end of REDIRECT, pc SHALL load the captured aligned target, and the FSM SHALL return to RUN.
REQ-027 Latency: a branch accepted at edge N SHALL produce flush in cycle N+2 and show the target on pc from cycle N+3.
REQ-028 taken_cnt SHALL increment by 1 at the end of each EVAL with taken=1, and SHALL saturate at 16'hFFFF.
REQ-029 br_valid asserted in EVAL or REDIRECT SHALL NOT be accepted; the requester SHALL hold it until br_ready is 1.

Reset
REQ-030 While rst_n is 0, regardless of clk, the block SHALL force state=RUN, pc=RESET_PC, br_taken=0, taken_cnt=0, flush=0, and clear the captured registers.
REQ-031 A reset asserted in EVAL or REDIRECT SHALL abort the branch with no redirect and no counter update.
REQ-032 After rst_n deasserts, the first pc advance SHALL occur at the first rising edge with en=1.

Verification
REQ-033 Sequential wrap: reset with RESET_PC=32'hFFFF_FFF8, en=1 -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 Unconditional branch: pc=0x100, accept opcode 10100 with target 0x2003 -> br_ready=0 for 2 cycles, flush=1 in cycle N+2, pc=0x2000 at N+3, taken_cnt=1.
REQ-035 Condition table: cover opcode 10000/10001/10010 with operand values 0x0, 0x1 and 0x8000_0000 -> br_taken patterns 0/0/1, 0/1/0 and 1/0/0 respectively; opcode 5'b00011 -> br_taken=0, no flush.
REQ-036 Not-taken and stall: en=0 while accepting 10010 with operand=5 -> pc unchanged throughout, flush never 1, br_ready returns to 1 at N+2.
REQ-037 Reset mid-branch: assert rst_n=0 asynchronously during EVAL -> immediately pc=RESET_PC, flush=0, taken_cnt=0, with no later redirect.
REQ-038 Saturation: issue 65536 taken branches -> taken_cnt stops at 16'hFFFF; one more taken branch leaves it at 16'hFFFF.
